// File: rtl/polyveck_w1_pack_stream_pkg.sv
// polyveck_w1_pack_stream_pkg: Dilithium3 parameters and shared types for w1 packing.
// The w1 range bound is derived from Q and GAMMA2 rather than hard-coded.
package polyveck_w1_pack_stream_pkg;
    localparam int K = 6;
    localparam int N = 256;
    localparam int Q = 8380417;
    localparam int GAMMA2 = (Q - 1) / 32;
    localparam int COEFF_W = 32;
    localparam int W1_BITS = 4;
    localparam int OUT_W = 32;
    localparam int W1_PACKED_BYTES = N * W1_BITS / 8;
    localparam int W1_MAX = (Q - 1) / (2 * GAMMA2) - 1;
    localparam int COEFFS = K * N;
    localparam int IN_W = COEFFS * COEFF_W;
    localparam int PACK_W = COEFFS * W1_BITS;
    localparam int WORDS = K * W1_PACKED_BYTES * 8 / OUT_W;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic logic w1_out_of_range(input logic [COEFF_W-1:0] c);
        return $signed(c) < 0 || $signed(c) > W1_MAX;
    endfunction
endpackage

// File: rtl/w1_word_select.sv
// w1_word_select: picks word word_cnt (8 consecutive coeff nibbles) out of the packed w1 vector.
module w1_word_select
    import polyveck_w1_pack_stream_pkg::*;
(
    input  logic [PACK_W-1:0] packed_w1,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic [OUT_W-1:0]  word
);
    logic [OUT_W-1:0] words [WORDS];

    for (genvar w = 0; w < WORDS; w++) begin : g_word
        assign words[w] = packed_w1[w*OUT_W +: OUT_W];
    end

    assign word = (word_cnt < CNT_W'(WORDS)) ? words[word_cnt] : '0;
endmodule

// File: rtl/polyveck_w1_pack_stream.sv
// polyveck_w1_pack_stream: captures a w1 vector in one handshake and streams its
// 4-bit packed encoding as 192 little-endian 32-bit words.
module polyveck_w1_pack_stream
    import polyveck_w1_pack_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   v1_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              range_err,
    output logic              done
);
    state_t state, state_n;
    logic [PACK_W-1:0] packed_w1, cap_w1;
    logic [COEFFS-1:0] bad;
    logic [CNT_W-1:0] word_cnt;
    logic [OUT_W-1:0] sel_word;
    logic take, give;

    // Coeff g lives at input lane g and packed nibble g, so word j is simply bits [32j +: 32].
    for (genvar g = 0; g < COEFFS; g++) begin : g_coeff
        assign cap_w1[g*W1_BITS +: W1_BITS] = v1_in[g*COEFF_W +: W1_BITS];
        assign bad[g] = w1_out_of_range(v1_in[g*COEFF_W +: COEFF_W]);
    end

    assign in_ready = state == IDLE && !rst;
    assign out_valid = state == STREAM;
    assign out_last = out_valid && word_cnt == LAST_WORD;
    assign out_data = out_valid ? sel_word : '0;
    assign take = in_valid && in_ready;
    assign give = out_valid && out_ready;

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (take ? STREAM : IDLE) : (give && out_last ? IDLE : STREAM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            word_cnt  <= '0;
            range_err <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_n;
            done  <= give && out_last;
            if (take)
                range_err <= |bad;
            if (give)
                word_cnt <= out_last ? '0 : word_cnt + CNT_W'(1);
        end
    end

    // Payload register needs no reset: out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (take)
            packed_w1 <= cap_w1;
    end

    w1_word_select u_sel (
        .packed_w1 (packed_w1),
        .word_cnt  (word_cnt),
        .word      (sel_word)
    );
endmodule
